seq_alu: RTL and testbench
==========================

# seq_alu

Parametrised, handshaked successor to the team's 16-bit combinational ALU. Accepts one operation at a time over a valid/ready input channel and returns a registered result, overflow word and pos/neg/zero flags over a valid/ready output channel. Single-cycle ops complete in one cycle; multiply runs as an iterative shift-add over WIDTH cycles. Sits between the register-file read stage and write-back of the datapath.

## Interface
- WIDTH, 16, operand/result width (≥4)
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  operation request
- in_ready  out  1  high only in IDLE
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- op  in  4  operation code
- out_valid  out  1  result valid, held until taken
- out_ready  in  1  consumer accepts result
- z  out  WIDTH  low half of 2·WIDTH result
- of  out  WIDTH  high half of 2·WIDTH result
- cc  out  3  {pos, neg, zero}
- err  out  1  illegal op code

## Operation
- op codes; R = {of, z} is the 2·WIDTH result:
  - 0000 add: z=A+B mod 2^W; of={0…0, carry}
  - 0001 and: z=A&B; of=0
  - 0010 pass A; 0011 pass B; of=0
  - 0100 not: z=~A (bitwise); of=0
  - 0101 mul: R=A·B unsigned, full 2·WIDTH product
  - 0110 shl: z={A[W-2:0],0}; of={0…0, A[W-1]}
  - 0111 asr: z={A[W-1],A[W-1:1]}; of=0
  - 1000 sub: z=A−B mod 2^W; of=all ones if A<B (unsigned borrow), else 0
  - others: illegal; z=0, of=0, err=1
- Flags from full R: zero=(R==0); neg=R[2W-1]; pos=!neg&&!zero. Exactly one bit set.
- err=0 for every legal op.
- FSM states IDLE, MUL, DONE; reset state IDLE.
  - IDLE: accept on in_valid&&in_ready; latch a, b, op. op 0101 → MUL with step counter=0; else compute, register outputs → DONE.
  - MUL: one shift-add step per cycle, counter increments; after WIDTH steps register product and flags → DONE.
  - DONE: out_valid=1; z/of/cc/err stable; on out_valid&&out_ready → IDLE.
- in_valid ignored outside IDLE; a/b/op may change freely after acceptance.

## Timing
- Reset (asynchronous): state=IDLE, out_valid=0, z=0, of=0, cc=000, err=0, counter=0; in_ready=1 once rst deasserts.
- Non-mul latency: accept at edge n → out_valid high after edge n+1.
- Mul latency: accept at edge n → out_valid high after edge n+WIDTH+1.
- Throughput: one op per (latency+1) cycles minimum; in_ready low during MUL and DONE, including the cycle a result is taken (no same-cycle accept).
- Backpressure: out_ready low holds DONE indefinitely; outputs unchanged.
- Reset mid-MUL or mid-DONE: operation discarded, all outputs return to reset values immediately.

## Configuration
- SEQ_ALU_MUL_EN defined: op 0101 uses the MUL state as above.
- Not defined: MUL state and multiplier datapath omitted; op 0101 is illegal (err=1, z=0, of=0, cc=001, latency 1).

## Test plan
- WIDTH=16, add 0xFFFF+0x0001 → z=0x0000, of=0x0001, cc=100, err=0, out_valid one cycle after accept.
- sub 0x0001−0x0002 → z=0xFFFF, of=0xFFFF, cc=010; sub 0x5555−0x5555 → z=0, of=0, cc=001.
- mul 0x1234·0x0010 (macro defined) → z=0x2340, of=0x0001, cc=100, out_valid exactly 17 cycles after accept; in_ready low throughout.
- op 1111 → err=1, z=0, of=0, cc=001; undefined macro + op 0101 → same.
- shl 0x8001 then out_ready held low 5 cycles → z=0x0002, of=0x0001 stable for all 5 cycles, in_ready low; taken on sixth.
- assert rst 3 cycles into mul → out_valid=0, z=0, of=0, cc=000 immediately; after release a new add 0x0002+0x0003 → z=0x0005, cc=100.

Source files
------------

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - handshaked sequential ALU with optional iterative multiplier
//
// Purpose: accepts one operation at a time over a valid/ready request channel
// and returns a registered 2*WIDTH result (of:z), pos/neg/zero flags and an
// illegal-op flag over a valid/ready result channel. Single-cycle ops go
// IDLE -> DONE; multiply walks IDLE -> MUL (WIDTH shift-add steps) -> DONE.
//
// Build option: define SEQ_ALU_MUL_EN to include the MUL state and the
// shift-add multiplier. Without it op 0101 is reported as illegal.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   operation request
//   in_ready   high only while IDLE
//   a, b       operands (WIDTH bits)
//   op         operation code (4 bits)
//   out_valid  result valid, held until out_ready
//   out_ready  consumer accepts result
//   z          low half of the 2*WIDTH result
//   of         high half of the 2*WIDTH result
//   cc         {pos, neg, zero} computed over the full 2*WIDTH result
//   err        illegal op code
module seq_alu #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic [WIDTH-1:0] of,
  output logic [2:0]       cc,
  output logic             err
);

`ifdef SEQ_ALU_MUL_EN
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, DONE} state_t;
`endif

  state_t state, state_next;

  // Flags are derived from the full 2*WIDTH result, so a carry or borrow
  // in the high half participates in zero/neg.
  function automatic logic [2:0] flags(input logic [2*WIDTH-1:0] r);
    logic zero;
    logic neg;
    zero = (r == '0);
    neg  = r[2*WIDTH-1];
    return {!neg && !zero, neg, zero};
  endfunction

  // Single-cycle datapath, evaluated directly on the presented operands.
  logic [WIDTH:0]   sum_add;
  logic [WIDTH-1:0] res_lo;
  logic [WIDTH-1:0] res_hi;
  logic             res_err;

  always_comb begin
    sum_add = {1'b0, a} + {1'b0, b};
    res_lo  = '0;
    res_hi  = '0;
    res_err = 1'b0;
    case (op)
      4'b0000: begin
        res_lo = sum_add[WIDTH-1:0];
        res_hi = {{(WIDTH-1){1'b0}}, sum_add[WIDTH]};
      end
      4'b0001: res_lo = a & b;
      4'b0010: res_lo = a;
      4'b0011: res_lo = b;
      4'b0100: res_lo = ~a;
`ifdef SEQ_ALU_MUL_EN
      4'b0101: res_lo = '0;  // product comes from the MUL state instead
`endif
      4'b0110: begin
        res_lo = {a[WIDTH-2:0], 1'b0};
        res_hi = {{(WIDTH-1){1'b0}}, a[WIDTH-1]};
      end
      4'b0111: res_lo = {a[WIDTH-1], a[WIDTH-1:1]};
      4'b1000: begin
        res_lo = a - b;
        res_hi = (a < b) ? '1 : '0;
      end
      default: res_err = 1'b1;
    endcase
  end

`ifdef SEQ_ALU_MUL_EN
  localparam int CW = $clog2(WIDTH + 1);

  logic              is_mul;
  logic [CW-1:0]     cnt;
  logic [WIDTH-1:0]  a_r;
  // acc holds {partial product high half, remaining multiplier bits}; each
  // step conditionally adds A into the high half and shifts everything right.
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH:0]     step_sum;
  logic [2*WIDTH-1:0] acc_next;
  logic               mul_last;

  assign is_mul   = (op == 4'b0101);
  assign step_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_r} : '0);
  assign acc_next = {step_sum, acc[WIDTH-1:1]};
  assign mul_last = (cnt == CW'(WIDTH - 1));
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state and handshake outputs
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
`ifdef SEQ_ALU_MUL_EN
          state_next = is_mul ? MUL : DONE;
`else
          state_next = DONE;
`endif
        end
      end
`ifdef SEQ_ALU_MUL_EN
      MUL: begin
        if (mul_last) state_next = DONE;
      end
`endif
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Result registers; they only change on acceptance or on the final
  // multiply step, so they stay stable while DONE waits for out_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      z   <= '0;
      of  <= '0;
      cc  <= '0;
      err <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
      cnt <= '0;
      a_r <= '0;
      acc <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
`ifdef SEQ_ALU_MUL_EN
            if (is_mul) begin
              a_r <= a;
              acc <= {{WIDTH{1'b0}}, b};
              cnt <= '0;
            end else begin
              z   <= res_lo;
              of  <= res_hi;
              cc  <= flags({res_hi, res_lo});
              err <= res_err;
            end
`else
            z   <= res_lo;
            of  <= res_hi;
            cc  <= flags({res_hi, res_lo});
            err <= res_err;
`endif
          end
        end
`ifdef SEQ_ALU_MUL_EN
        MUL: begin
          acc <= acc_next;
          cnt <= cnt + 1'b1;
          if (mul_last) begin
            z   <= acc_next[WIDTH-1:0];
            of  <= acc_next[2*WIDTH-1:WIDTH];
            cc  <= flags(acc_next);
            err <= 1'b0;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - scoreboard testbench for seq_alu (WIDTH=16)
module tb_seq_alu;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [3:0]   op = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] z;
  logic [W-1:0] of;
  logic [2:0]   cc;
  logic         err;

  seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op),
    .out_valid(out_valid), .out_ready(out_ready),
    .z(z), .of(of), .cc(cc), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] z;
    logic [W-1:0] of;
    logic [2:0]   cc;
    logic         err;
  } res_t;

  res_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

`ifdef SEQ_ALU_MUL_EN
  localparam int MUL_LAT = W + 1;
`else
  localparam int MUL_LAT = 1;
`endif

  function automatic res_t model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [2*W-1:0] r;
    res_t m;
    r = '0;
    m.err = 1'b0;
    case (o)
      4'b0000: r = {{W{1'b0}}, x} + {{W{1'b0}}, y};
      4'b0001: r = {{W{1'b0}}, x & y};
      4'b0010: r = {{W{1'b0}}, x};
      4'b0011: r = {{W{1'b0}}, y};
      4'b0100: r = {{W{1'b0}}, ~x};
`ifdef SEQ_ALU_MUL_EN
      4'b0101: r = (2*W)'(x) * (2*W)'(y);
`endif
      4'b0110: r = (2*W)'(x) * 2;
      4'b0111: r = {{W{1'b0}}, 16'($signed(x) >>> 1)};
      4'b1000: r = {(x < y) ? {W{1'b1}} : {W{1'b0}}, 16'(x - y)};
      default: m.err = 1'b1;
    endcase
    m.z  = r[W-1:0];
    m.of = r[2*W-1:W];
    m.cc = (r == '0) ? 3'b001 : (r[2*W-1] ? 3'b010 : 3'b100);
    return m;
  endfunction

  // Present one op at a negedge, push its expected result, let it be accepted.
  task automatic send(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y, output logic rdy);
    @(negedge clk);
    rdy      = in_ready;
    in_valid = 1'b1;
    op = o; a = x; b = y;
    exp_q.push_back(model(o, x, y));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a  = W'($urandom);
    b  = W'($urandom);
    op = 4'($urandom);
  endtask

  // Latency counted with the accept cycle as 1; bounded wait.
  task automatic wait_out(output int lat, output bit timed_out, output int ready_high);
    lat = 1;
    ready_high = 0;
    while (!out_valid && lat < 100) begin
      if (in_ready) ready_high++;
      @(posedge clk);
      #1;
      lat++;
    end
    timed_out = !out_valid;
  endtask

  task automatic take;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, z, of, cc, err} !== '0)
      begin errors++; $display("FAIL reset_outputs: got valid=%b z=%h of=%h cc=%b err=%b, expected all zero", out_valid, z, of, cc, err); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b, expected 1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, expected 0", out_valid); end
  endtask

  task automatic test_single_cycle;
    logic [3:0] ops[13] = '{4'b0000, 4'b1000, 4'b1000, 4'b0001, 4'b0010, 4'b0011,
                            4'b0100, 4'b0110, 4'b0111, 4'b1111, 4'b1010, 4'b0000, 4'b0111};
    logic [W-1:0] as[13] = '{16'hFFFF, 16'h0001, 16'h5555, 16'hF0F0, 16'h8000, 16'h1234,
                             16'h0000, 16'h4001, 16'h8002, 16'h1234, 16'hFFFF, 16'h7000, 16'h0001};
    logic [W-1:0] bs[13] = '{16'h0001, 16'h0002, 16'h5555, 16'h3C3C, 16'h0001, 16'h8765,
                             16'h1111, 16'h0000, 16'h0000, 16'h4321, 16'hFFFF, 16'h1000, 16'h0000};
    res_t e, g;
    int lat, rh;
    bit to;
    logic rdy;
    for (int i = 0; i < 13; i++) begin
      send(ops[i], as[i], bs[i], rdy);
      wait_out(lat, to, rh);
      e = exp_q.pop_front();
      g = {z, of, cc, err};
      checks++;
      if (rdy !== 1'b1) begin errors++; $display("FAIL op%0d_ready: got %b, expected 1", i, rdy); end
      checks++;
      if (to) begin errors++; $display("FAIL op%0d_timeout: out_valid never rose, expected within 1 cycle", i); end
      checks++;
      if (lat != 1) begin errors++; $display("FAIL op%0d_latency: got %0d, expected 1", i, lat); end
      checks++;
      if (g !== e)
        begin errors++; $display("FAIL op%0d_result op=%b: got z=%h of=%h cc=%b err=%b, expected z=%h of=%h cc=%b err=%b",
                                 i, ops[i], g.z, g.of, g.cc, g.err, e.z, e.of, e.cc, e.err); end
      take;
    end
  endtask

  task automatic test_mul;
    logic [W-1:0] as[3] = '{16'h1234, 16'hFFFF, 16'h0000};
    logic [W-1:0] bs[3] = '{16'h0010, 16'hFFFF, 16'hABCD};
    res_t e, g;
    int lat, rh;
    bit to;
    logic rdy;
    for (int i = 0; i < 3; i++) begin
      send(4'b0101, as[i], bs[i], rdy);
      wait_out(lat, to, rh);
      e = exp_q.pop_front();
      g = {z, of, cc, err};
      checks++;
      if (to) begin errors++; $display("FAIL mul%0d_timeout: out_valid never rose", i); end
      checks++;
      if (lat != MUL_LAT) begin errors++; $display("FAIL mul%0d_latency: got %0d, expected %0d", i, lat, MUL_LAT); end
      checks++;
      if (rh != 0) begin errors++; $display("FAIL mul%0d_in_ready: high in %0d busy cycles, expected 0", i, rh); end
      checks++;
      if (g !== e)
        begin errors++; $display("FAIL mul%0d_result: got z=%h of=%h cc=%b err=%b, expected z=%h of=%h cc=%b err=%b",
                                 i, g.z, g.of, g.cc, g.err, e.z, e.of, e.cc, e.err); end
      take;
    end
  endtask

  task automatic test_backpressure;
    res_t e, g;
    int lat, rh;
    bit to;
    logic rdy;
    send(4'b0110, 16'h8001, 16'h0000, rdy);
    wait_out(lat, to, rh);
    e = exp_q.pop_front();
    checks++;
    if (to) begin errors++; $display("FAIL bp_timeout: out_valid never rose"); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      g = {z, of, cc, err};
      checks++;
      if (g !== e || out_valid !== 1'b1 || in_ready !== 1'b0)
        begin errors++; $display("FAIL bp_hold%0d: got z=%h of=%h valid=%b ready=%b, expected z=%h of=%h valid=1 ready=0",
                                 i, g.z, g.of, out_valid, in_ready, e.z, e.of); end
    end
    take;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      begin errors++; $display("FAIL bp_taken: got valid=%b ready=%b, expected valid=0 ready=1", out_valid, in_ready); end
  endtask

  task automatic test_reset_mid_op;
    res_t e, g;
    int lat, rh;
    bit to;
    logic rdy;
    // Leave a nonzero result in the output registers first.
    send(4'b0100, 16'h0000, 16'h0000, rdy);
    wait_out(lat, to, rh);
    void'(exp_q.pop_front());
    take;
`ifdef SEQ_ALU_MUL_EN
    send(4'b0101, 16'h1234, 16'h0010, rdy);
    repeat (2) @(posedge clk);
`else
    send(4'b0000, 16'h0001, 16'h0001, rdy);
`endif
    #2;
    rst = 1'b1;
    #1;
    void'(exp_q.pop_front());
    checks++;
    if ({out_valid, z, of, cc, err} !== '0)
      begin errors++; $display("FAIL midreset_outputs: got valid=%b z=%h of=%h cc=%b err=%b, expected all zero", out_valid, z, of, cc, err); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    send(4'b0000, 16'h0002, 16'h0003, rdy);
    wait_out(lat, to, rh);
    e = exp_q.pop_front();
    g = {z, of, cc, err};
    checks++;
    if (rdy !== 1'b1 || to || lat != 1) begin errors++; $display("FAIL post_reset_handshake: got ready=%b timeout=%b lat=%0d, expected 1 0 1", rdy, to, lat); end
    checks++;
    if (g !== e)
      begin errors++; $display("FAIL post_reset_add: got z=%h of=%h cc=%b err=%b, expected z=%h of=%h cc=%b err=%b",
                               g.z, g.of, g.cc, g.err, e.z, e.of, e.cc, e.err); end
    take;
  endtask

  task automatic test_back_to_back;
    localparam int N = 8;
    logic [3:0] ops[N] = '{4'b0000, 4'b1000, 4'b0101, 4'b0100, 4'b0111, 4'b0101, 4'b0001, 4'b1100};
    res_t e, g;
    int n_acc, n_done;
    n_acc = 0;
    n_done = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 600 && n_done < N; cyc++) begin
      @(negedge clk);
      checks++;
      if (in_ready && out_valid) begin errors++; $display("FAIL b2b_overlap: in_ready and out_valid both high at cycle %0d", cyc); end
      if (out_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL b2b_unexpected: result with empty scoreboard, got z=%h", z);
        end else begin
          e = exp_q.pop_front();
          g = {z, of, cc, err};
          if (g !== e)
            begin errors++; $display("FAIL b2b_result%0d: got z=%h of=%h cc=%b err=%b, expected z=%h of=%h cc=%b err=%b",
                                     n_done, g.z, g.of, g.cc, g.err, e.z, e.of, e.cc, e.err); end
        end
        n_done++;
      end
      if (in_ready && n_acc < N) begin
        in_valid = 1'b1;
        op = ops[n_acc];
        a  = W'($urandom);
        b  = W'($urandom);
        exp_q.push_back(model(op, a, b));
        n_acc++;
      end else begin
        in_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    checks++;
    if (n_done != N || exp_q.size() != 0)
      begin errors++; $display("FAIL b2b_count: got %0d results, %0d pending, expected %0d and 0", n_done, exp_q.size(), N); end
  endtask

  initial begin
    test_reset;
    test_single_cycle;
    test_mul;
    test_backpressure;
    test_reset_mid_op;
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
